serial_add_seq: RTL and testbench
=================================

# serial_add_seq

Bit-serial adder sequencer. Accepts two N-bit operands and a carry-in over a valid/ready handshake, then drives one shared one-bit full-adder cell (LUT4 sum plus SB_CARRY carry) for N cycles, LSB first. It returns the N-bit sum and carry-out over a second valid/ready handshake. It sits between a requester and the one-bit add cell, trading N cycles of latency for one adder's worth of logic on the icestick fabric.

## Interface

Parameters
- N, 8, operand width in bits; legal range N >= 1.

Ports
- CLKIN  input  1  single clock; all state changes on its rising edge.
- RESETN  input  1  reset, asynchronous, active-low.
- A  input  N  operand A; sampled only on accept.
- B  input  N  operand B; sampled only on accept.
- CIN  input  1  carry-in; sampled only on accept.
- I_VALID  input  1  requester has an operand set.
- I_READY  output  1  block can accept; equals (state == IDLE).
- O  output  N  sum, registered; valid while O_VALID = 1.
- COUT  output  1  carry-out, registered; valid while O_VALID = 1.
- O_VALID  output  1  result available; equals (state == HOLD).
- O_READY  input  1  consumer takes the result.

## Operation

- Internal state:
  - a_sr and b_sr: N-bit operand shift registers.
  - c_reg: 1-bit carry register.
  - s_sr: N-bit partial-sum shift register.
  - cnt: counter of width max(1, clog2(N)).
  - O_reg and COUT_reg: output holding registers.
  - FSM with states IDLE, RUN, HOLD.
- The adder cell sees I0 = a_sr[0], I1 = b_sr[0], CIN = c_reg. It is combinational; its outputs are captured at each RUN edge.
- IDLE:
  - I_READY = 1.
  - On an edge with I_VALID = 1: a_sr <= A, b_sr <= B, c_reg <= CIN, cnt <= 0, go to RUN.
  - If I_VALID = 0, stay in IDLE.
- RUN, one bit per edge:
  - s_sr <= {sum, s_sr[N-1:1]}.
  - c_reg <= carry-out.
  - a_sr and b_sr shift right by one; cnt <= cnt + 1.
  - When cnt == N-1 on that edge: O_reg <= {sum, s_sr[N-1:1]}, COUT_reg <= carry-out, go to HOLD.
  - I_VALID is ignored throughout RUN.
- HOLD:
  - O_VALID = 1; O and COUT are held stable.
  - On an edge with O_READY = 1, go to IDLE.
  - I_VALID is ignored.
- O and COUT change only on the RUN-to-HOLD edge. They keep the last result in IDLE and RUN.
- Arithmetic: {COUT, O} = A + B + CIN, modulo 2^(N+1); no overflow beyond COUT. The operands are unsigned; two's-complement callers use O as-is.
- No input buffering. An I_VALID held while I_READY = 0 is neither captured nor queued; the requester must hold it until I_READY = 1.
- N = 1: RUN lasts exactly one edge (cnt == 0 == N-1).

## Timing

- Reset (RESETN low, asynchronous):
  - State IDLE; all registers cleared.
  - O = 0, COUT = 0, O_VALID = 0.
  - I_READY = 0 while RESETN is low, 1 from the first cycle after release.
- Release of RESETN is synchronised internally. The first accept is possible on the second rising edge after release.
- Accept on edge k, meaning state IDLE and I_VALID = 1 at edge k:
  - Edges k+1 .. k+N process bits 0 .. N-1.
  - O_VALID = 1 in the cycle after edge k+N, so latency is N cycles.
- Return to IDLE on the first edge in HOLD with O_READY = 1. With O_READY tied high, HOLD lasts exactly one cycle.
- Minimum accept-to-accept period: N+2 cycles.
- O_READY = 1 outside HOLD has no effect.
- Reset asserted mid-RUN or mid-HOLD aborts the operation. Partial results are discarded, and outputs take their reset values immediately (asynchronously).

## Test plan

- Reset: RESETN low for 3 cycles during random I_VALID -> O = 0, COUT = 0, O_VALID = 0, I_READY = 0. After release, I_READY = 1 by the second edge.
- Basic add, N = 8: A = 0x5A, B = 0x33, CIN = 0 -> O = 0x8D, COUT = 0, with O_VALID rising exactly 8 cycles after the accept edge.
- Carry chain, N = 8:
  - A = 0xFF, B = 0x01, CIN = 0 -> O = 0x00, COUT = 1.
  - A = 0xFF, B = 0xFF, CIN = 1 -> O = 0xFF, COUT = 1.
- Backpressure: O_READY = 0 for 5 cycles in HOLD, while A, B, CIN and I_VALID toggle -> O_VALID stays 1, O and COUT are unchanged, I_READY = 0, and no new transaction starts. Raising O_READY returns to IDLE on the next edge.
- Reset mid-RUN: assert RESETN low after bit 3 of A = 0x0F, B = 0xF0 -> outputs go to 0 immediately. After release, A = 0x01, B = 0x02, CIN = 1 -> O = 0x04, COUT = 0.
- Back-to-back: I_VALID and O_READY tied high with 4 consecutive operand sets -> accepts occur every 10 cycles (N+2), and each result matches A + B + CIN.

Source files
------------

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial adder sequencer around one shared full-adder cell
//
// Adds two N-bit unsigned operands plus a carry-in, one bit per clock, LSB first,
// using a single one-bit full-adder cell. Result is {COUT, O} = A + B + CIN.
//
// Ports:
//   CLKIN    in   1  clock, rising edge
//   RESETN   in   1  asynchronous active-low reset
//   A, B     in   N  operands, sampled on accept
//   CIN      in   1  carry-in, sampled on accept
//   I_VALID  in   1  request handshake valid
//   I_READY  out  1  request handshake ready (IDLE and out of reset)
//   O        out  N  registered sum, valid while O_VALID
//   COUT     out  1  registered carry-out, valid while O_VALID
//   O_VALID  out  1  result handshake valid (HOLD)
//   O_READY  in   1  result handshake ready
module serial_add_seq #(
    parameter int N = 8
) (
    input  logic         CLKIN,
    input  logic         RESETN,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CIN,
    input  logic         I_VALID,
    output logic         I_READY,
    output logic [N-1:0] O,
    output logic         COUT,
    output logic         O_VALID,
    input  logic         O_READY
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  a_sr_q, a_sr_d;
    logic [N-1:0]  b_sr_q, b_sr_d;
    logic          c_q, c_d;
    logic [N-1:0]  s_sr_q, s_sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  o_q, o_d;
    logic          cout_q, cout_d;
    logic          rst_sync_q;

    logic          cell_sum;
    logic          cell_carry;
    logic [N-1:0]  s_shift;

    // The shared one-bit add cell: sum from a 3-input XOR, carry as majority.
    assign cell_sum   = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    assign cell_carry = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);

    // New sum bit enters at the MSB so that after N shifts bit 0 sits at the LSB.
    // Built this way rather than with a concatenation so N = 1 stays legal.
    always_comb begin
        s_shift        = s_sr_q >> 1;
        s_shift[N-1]   = cell_sum;
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        c_d     = c_q;
        s_sr_d  = s_sr_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                // rst_sync_q keeps the first edge after reset release from accepting.
                if (I_VALID && rst_sync_q) begin
                    a_sr_d  = A;
                    b_sr_d  = B;
                    c_d     = CIN;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_sr_d = s_shift;
                c_d    = cell_carry;
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    o_d     = s_shift;
                    cout_d  = cell_carry;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (O_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            rst_sync_q <= 1'b0;
            state_q    <= ST_IDLE;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            c_q        <= 1'b0;
            s_sr_q     <= '0;
            cnt_q      <= '0;
            o_q        <= '0;
            cout_q     <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
            state_q    <= state_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            c_q        <= c_d;
            s_sr_q     <= s_sr_d;
            cnt_q      <= cnt_d;
            o_q        <= o_d;
            cout_q     <= cout_d;
        end
    end

    assign I_READY = (state_q == ST_IDLE) && rst_sync_q;
    assign O_VALID = (state_q == ST_HOLD);
    assign O       = o_q;
    assign COUT    = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - self-checking bench for serial_add_seq
module tb_serial_add_seq;

    localparam int N = 8;

    logic         CLKIN = 1'b0;
    logic         RESETN;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         CIN;
    logic         I_VALID;
    logic         I_READY;
    logic [N-1:0] O;
    logic         COUT;
    logic         O_VALID;
    logic         O_READY;

    int total = 0;
    int bad   = 0;

    serial_add_seq #(.N(N)) dut (
        .CLKIN   (CLKIN),
        .RESETN  (RESETN),
        .A       (A),
        .B       (B),
        .CIN     (CIN),
        .I_VALID (I_VALID),
        .I_READY (I_READY),
        .O       (O),
        .COUT    (COUT),
        .O_VALID (O_VALID),
        .O_READY (O_READY)
    );

    always #5 CLKIN = ~CLKIN;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    endfunction

    // One transaction; all driving and sampling happens on the falling edge.
    task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input int hold);
        logic [N:0] exp;
        int lat;
        exp = model(a, b, c);
        check("idle_rdy", I_READY, 1);
        A       = a;
        B       = b;
        CIN     = c;
        I_VALID = 1'b1;
        O_READY = (hold == 0);
        @(negedge CLKIN);
        I_VALID = 1'b0;
        A       = N'($urandom);
        B       = N'($urandom);
        CIN     = 1'($urandom);
        check("run_busy", I_READY, 0);
        lat = 0;
        while (!O_VALID && lat < N + 4) begin
            @(negedge CLKIN);
            lat++;
        end
        check("latency", lat, N);
        check("sum", O, exp[N-1:0]);
        check("cout", COUT, exp[N]);
        for (int i = 0; i < hold; i++) begin
            I_VALID = 1'($urandom);
            A       = N'($urandom);
            B       = N'($urandom);
            CIN     = 1'($urandom);
            @(negedge CLKIN);
            check("hold_valid", O_VALID, 1);
            check("hold_sum", O, exp[N-1:0]);
            check("hold_cout", COUT, exp[N]);
            check("hold_rdy", I_READY, 0);
        end
        O_READY = 1'b1;
        I_VALID = 1'b0;
        @(negedge CLKIN);
        check("rel_valid", O_VALID, 0);
        check("rel_rdy", I_READY, 1);
        check("kept_sum", {COUT, O}, exp);
    endtask

    initial begin
        logic [N:0]   exp_q[$];
        int           acc_cyc[$];
        logic [N-1:0] ta[4];
        logic [N-1:0] tbv[4];
        logic         tc[4];
        int           cyc;
        int           sets;
        int           got;

        RESETN  = 1'b0;
        A       = '0;
        B       = '0;
        CIN     = 1'b0;
        I_VALID = 1'b0;
        O_READY = 1'b0;

        repeat (3) begin
            I_VALID = 1'($urandom);
            A       = N'($urandom);
            B       = N'($urandom);
            @(negedge CLKIN);
            check("rst_o", O, 0);
            check("rst_cout", COUT, 0);
            check("rst_valid", O_VALID, 0);
            check("rst_rdy", I_READY, 0);
        end
        I_VALID = 1'b0;
        RESETN  = 1'b1;
        @(negedge CLKIN);
        check("post_rst_rdy", I_READY, 1);

        run_txn(8'h5A, 8'h33, 1'b0, 0);
        run_txn(8'hFF, 8'h01, 1'b0, 0);
        run_txn(8'hFF, 8'hFF, 1'b1, 5);

        // Abort mid-RUN: outputs must clear without waiting for a clock edge.
        A       = 8'h0F;
        B       = 8'hF0;
        CIN     = 1'b0;
        I_VALID = 1'b1;
        O_READY = 1'b1;
        @(negedge CLKIN);
        I_VALID = 1'b0;
        repeat (4) @(negedge CLKIN);
        #2 RESETN = 1'b0;
        #1;
        check("abort_o", O, 0);
        check("abort_cout", COUT, 0);
        check("abort_valid", O_VALID, 0);
        check("abort_rdy", I_READY, 0);
        @(negedge CLKIN);
        RESETN = 1'b1;
        @(negedge CLKIN);
        run_txn(8'h01, 8'h02, 1'b1, 0);

        repeat (6) begin
            run_txn(N'($urandom), N'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        // Back-to-back with both handshakes held high.
        ta[0] = 8'hFF; tbv[0] = 8'h01; tc[0] = 1'b1;
        for (int i = 1; i < 4; i++) begin
            ta[i]  = N'($urandom);
            tbv[i] = N'($urandom);
            tc[i]  = 1'($urandom);
        end
        O_READY = 1'b1;
        cyc  = 0;
        sets = 0;
        got  = 0;
        while (got < 4 && cyc < 200) begin
            if (O_VALID && exp_q.size() > 0) begin
                check("b2b_sum", {COUT, O}, exp_q.pop_front());
                got++;
            end
            if (I_READY && sets < 4) begin
                A       = ta[sets];
                B       = tbv[sets];
                CIN     = tc[sets];
                I_VALID = 1'b1;
                exp_q.push_back(model(ta[sets], tbv[sets], tc[sets]));
                acc_cyc.push_back(cyc);
                sets++;
            end else if (I_READY) begin
                I_VALID = 1'b0;
            end
            @(negedge CLKIN);
            cyc++;
        end
        check("b2b_results", got, 4);
        check("b2b_accepts", acc_cyc.size(), 4);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check("b2b_period", acc_cyc[i] - acc_cyc[i-1], N + 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
